acq_sequencer: RTL and testbench

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_sequencer.sv | 151 +++++++++++++++
 tb/tb_acq_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// acq_sequencer: per-trigger FIFO read sequencer that drops SKIP leading words and
// strobes the accumulator for POINTS words, repeated MEASURES times per frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, begins a frame when idle
//   abort        level, terminates the current frame (sets err)
//   trig         one-cycle trigger pulse, one per measurement
//   fifo_empty   show-ahead FIFO empty flag
//   fifo_rdreq   FIFO read strobe (combinational, READ only)
//   acc_en       accumulator add strobe for non-skipped words
//   cnt_point    index of the word being read (0..SKIP+POINTS-1)
//   cnt_measure  index of the current measurement (0..MEASURES-1)
//   busy         high from accepted start until frame end
//   done         one-cycle frame-complete pulse
//   err          sticky error flag, cleared by the next accepted start
//
// Optional feature: define ACQ_TIMEOUT_EN to abandon a frame (with err) when no
// trig arrives within TMO_CYCLES clocks of entering ARM.
module acq_sequencer #(
    parameter int POINTS     = 1024,
    parameter int MEASURES   = 100000,
    parameter int SKIP       = 5,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        trig,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic        acc_en,
    output logic [10:0] cnt_point,
    output logic [16:0] cnt_measure,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [10:0] LAST_PT = 11'(SKIP + POINTS - 1);
    localparam logic [10:0] SKIP_PT = 11'(SKIP);
    localparam logic [16:0] LAST_MS = 17'(MEASURES - 1);

    typedef enum logic [2:0] {IDLE, ARM, READ, GAP, FINISH} state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_point_q, cnt_point_d;
    logic [16:0] cnt_measure_q, cnt_measure_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
`ifdef ACQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_point_d   = cnt_point_q;
        cnt_measure_d = cnt_measure_q;
        busy_d        = busy_q;
        err_d         = err_q;
        fifo_rdreq    = 1'b0;
        acc_en        = 1'b0;
        done          = 1'b0;
`ifdef ACQ_TIMEOUT_EN
        tmo_d         = '0;
`endif
        // Abort outranks everything, including a trig or the final read in the same cycle.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d       = ARM;
                    cnt_point_d   = '0;
                    cnt_measure_d = '0;
                    busy_d        = 1'b1;
                    err_d         = 1'b0;
                end
                ARM: begin
                    if (trig) state_d = READ;
`ifdef ACQ_TIMEOUT_EN
                    else begin
                        tmo_d = tmo_q + 1'b1;
                        if (tmo_q == TW'(TMO_CYCLES - 1)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end
                    end
`endif
                end
                READ: begin
                    fifo_rdreq = !fifo_empty;
                    acc_en     = !fifo_empty && cnt_point_q >= SKIP_PT;
                    if (trig) err_d = 1'b1;
                    // The index parks on the last word so it never wraps; GAP rewinds it.
                    if (!fifo_empty) begin
                        if (cnt_point_q == LAST_PT) state_d = GAP;
                        else cnt_point_d = cnt_point_q + 1'b1;
                    end
                end
                GAP: begin
                    if (trig) err_d = 1'b1;
                    if (cnt_measure_q == LAST_MS) state_d = FINISH;
                    else begin
                        state_d       = ARM;
                        cnt_measure_d = cnt_measure_q + 1'b1;
                        cnt_point_d   = '0;
                    end
                end
                FINISH: begin
                    done    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_point_q   <= '0;
            cnt_measure_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_point_q   <= cnt_point_d;
            cnt_measure_q <= cnt_measure_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
`ifdef ACQ_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign cnt_point   = cnt_point_q;
    assign cnt_measure = cnt_measure_q;
    assign busy        = busy_q;
    assign err         = err_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed bench for acq_sequencer with POINTS=4, SKIP=5, MEASURES=3.
module tb_acq_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        trig = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        fifo_rdreq, acc_en, busy, done, err;
    logic [10:0] cnt_point;
    logic [16:0] cnt_measure;
    int          errors = 0;
    int          checks = 0;

    acq_sequencer #(.POINTS(4), .MEASURES(3), .SKIP(5), .TMO_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
        .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq), .acc_en(acc_en),
        .cnt_point(cnt_point), .cnt_measure(cnt_measure), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives one measurement from ARM through GAP; returns the number of reads seen
    // and the number of cycles whose outputs disagreed with the expected sequence.
    task automatic read_measure(input bit stall, input int trig_at, output int reads, output int bad);
        int pt = 0;
        int c = 0;
        reads = 0;
        bad = 0;
        fifo_empty = 1'b0;
        trig = 1'b1;
        #1;
        if (fifo_rdreq !== 1'b0 || acc_en !== 1'b0) bad++;
        tick();
        while (reads < 9 && c < 40) begin
            fifo_empty = stall ? c[0] : 1'b0;
            trig = (c == trig_at);
            #1;
            if (fifo_rdreq !== !fifo_empty) bad++;
            if (cnt_point !== 11'(pt)) bad++;
            if (acc_en !== (!fifo_empty && pt >= 5)) bad++;
            if (done !== 1'b0) bad++;
            if (fifo_rdreq === 1'b1) begin
                reads++;
                pt++;
            end
            tick();
            c++;
        end
        trig = 1'b0;
        fifo_empty = 1'b0;
        #1;
        if (fifo_rdreq !== 1'b0 || acc_en !== 1'b0) bad++;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (fifo_rdreq !== 1'b0 || acc_en !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rdreq=%b acc_en=%b want 0 0", fifo_rdreq, acc_en); end
        checks++; if (cnt_point !== 11'd0 || cnt_measure !== 17'd0) begin errors++; $display("FAIL reset_counters: got pt=%0d ms=%0d want 0 0", cnt_point, cnt_measure); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy, done, err}); end
        #10 rst = 1'b0;
        tick();
    endtask

    task automatic run_frame(input string name, input bit stall, input int trig_at, input bit exp_err);
        int reads, bad;
        pulse_start();
        checks++; if (busy !== 1'b1 || err !== 1'b0 || cnt_measure !== 17'd0 || cnt_point !== 11'd0) begin errors++; $display("FAIL %s_start: got busy=%b err=%b pt=%0d ms=%0d want 1 0 0 0", name, busy, err, cnt_point, cnt_measure); end
        for (int m = 0; m < 3; m++) begin
            checks++; if (cnt_measure !== 17'(m) || cnt_point !== 11'd0) begin errors++; $display("FAIL %s_arm%0d: got ms=%0d pt=%0d want %0d 0", name, m, cnt_measure, cnt_point, m); end
            read_measure(stall, m == 0 ? trig_at : -1, reads, bad);
            checks++; if (reads !== 9 || bad !== 0) begin errors++; $display("FAIL %s_meas%0d: got reads=%0d bad=%0d want 9 0", name, m, reads, bad); end
        end
        #1;
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s_done: got done=%b busy=%b want 1 1", name, done, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cnt_measure !== 17'd2 || err !== exp_err) begin errors++; $display("FAIL %s_end: got done=%b busy=%b ms=%0d err=%b want 0 0 2 %b", name, done, busy, cnt_measure, err, exp_err); end
    endtask

    task automatic test_basic();
        run_frame("basic", 1'b0, -1, 1'b0);
    endtask

    task automatic test_stall();
        run_frame("stall", 1'b1, -1, 1'b0);
    endtask

    task automatic test_overrun();
        run_frame("overrun", 1'b0, 3, 1'b1);
    endtask

    task automatic test_abort();
        int reads, bad, dones;
        pulse_start();
        read_measure(1'b0, -1, reads, bad);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        #1;
        checks++; if (cnt_point !== 11'd6 || cnt_measure !== 17'd1) begin errors++; $display("FAIL abort_pos: got pt=%0d ms=%0d want 6 1", cnt_point, cnt_measure); end
        checks++; if (fifo_rdreq !== 1'b0 || acc_en !== 1'b0) begin errors++; $display("FAIL abort_strobes: got rdreq=%b acc_en=%b want 0 0", fifo_rdreq, acc_en); end
        tick();
        abort = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done !== 1'b0 || fifo_rdreq !== 1'b0) dones++;
            tick();
        end
        checks++; if (busy !== 1'b0 || err !== 1'b1 || dones !== 0) begin errors++; $display("FAIL abort_idle: got busy=%b err=%b bad_cycles=%0d want 0 1 0", busy, err, dones); end
        pulse_start();
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_restart: got err=%b busy=%b want 0 1", err, busy); end
        trig = 1'b1;
        abort = 1'b1;
        tick();
        trig = 1'b0;
        abort = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b1 || fifo_rdreq !== 1'b0) begin errors++; $display("FAIL abort_vs_trig: got busy=%b err=%b rdreq=%b want 0 1 0", busy, err, fifo_rdreq); end
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_rdreq !== 1'b1 || cnt_point !== 11'd3) begin errors++; $display("FAIL rstmid_pre: got rdreq=%b pt=%0d want 1 3", fifo_rdreq, cnt_point); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({fifo_rdreq, acc_en, busy, done, err} !== 5'b0 || cnt_point !== 11'd0 || cnt_measure !== 17'd0) begin errors++; $display("FAIL rstmid_outputs: got flags=%b pt=%0d ms=%0d want 0 0 0", {fifo_rdreq, acc_en, busy, done, err}, cnt_point, cnt_measure); end
        #1 rst = 1'b0;
        tick();
        tick();
        run_frame("rstmid", 1'b0, -1, 1'b0);
    endtask

    task automatic test_timeout();
        pulse_start();
`ifdef ACQ_TIMEOUT_EN
        repeat (49) tick();
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL tmo_early: got busy=%b err=%b want 1 0", busy, err); end
        tick();
        checks++; if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL tmo_fire: got busy=%b err=%b done=%b want 0 1 0", busy, err, done); end
`else
        repeat (1000) tick();
        checks++; if (busy !== 1'b1 || err !== 1'b0 || cnt_point !== 11'd0) begin errors++; $display("FAIL arm_wait: got busy=%b err=%b pt=%0d want 1 0 0", busy, err, cnt_point); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
